rr_arbiter: RTL and testbench

Parametrised N-way arbiter with registered one-hot grant. Supports round-robin or fixed-priority selection, optional grant locking, and a starvation-limiting hold counter. Sits between N requesters and one shared resource; next generation of the team's 3-input fixed arbiter.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 27 ++
 rtl/rr_arbiter.sv | 109 ++++++++++
 tb/tb_rr_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbiter family.
package arb_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority pick: first set bit of req at or above start, wrapping.
module rr_pick #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   pick,
  output logic           found
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] back;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_pick;

  // Rotate so start sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl      = {req, req} >> start;
    rot      = dbl[N-1:0];
    rot_pick = rot & (~rot + N'(1));
    back     = {rot_pick, rot_pick} << start;
    pick     = back[2*N-1:N];
    found    = |req;
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant: round-robin or fixed priority,
// optional grant locking bounded by a hold counter.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MODE     = MODE_RR,
  parameter int unsigned LOCK     = 1,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDW      = clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   request,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid
);

  localparam int unsigned HW       = (MAX_HOLD < 2) ? 1 : clog2(MAX_HOLD + 1);
  localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam bit          LOCK_EN  = (LOCK != 0);
  localparam bit          FIXED    = (MODE == MODE_FIXED);

  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           grant_valid_q, grant_valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           owned_c, others_c, keep_c, expire_c;
  logic [N-1:0]   req_m_c;
  logic [IDW-1:0] start_c;
  logic [N-1:0]   pick_c;
  logic           found_c;
  logic [IDW-1:0] pick_id_c;

  // Lock decision; an expired hold masks the grantee so someone else wins.
  always_comb begin
    owned_c  = |(grant_q & request);
    others_c = |(request & ~grant_q);
    keep_c   = LOCK_EN && owned_c &&
               ((MAX_HOLD == 0) || (hold_q < HW'(HOLD_LIM)) || !others_c);
    expire_c = LOCK_EN && owned_c && !keep_c;
    req_m_c  = expire_c ? (request & ~grant_q) : request;
    if (FIXED) begin
      start_c = '0;
    end else begin
      start_c = (ptr_q == IDW'(N - 1)) ? '0 : ptr_q + IDW'(1);
    end
  end

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req_m_c),
    .start (start_c),
    .pick  (pick_c),
    .found (found_c)
  );

  always_comb begin
    pick_id_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_c[i]) pick_id_c = pick_id_c | IDW'(i);
    end
  end

  always_comb begin
    grant_d       = '0;
    grant_id_d    = '0;
    grant_valid_d = 1'b0;
    ptr_d         = ptr_q;
    hold_d        = '0;
    if (keep_c) begin
      grant_d       = grant_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = 1'b1;
      hold_d        = (&hold_q) ? hold_q : hold_q + HW'(1);
    end else if (found_c) begin
      grant_d       = pick_c;
      grant_id_d    = pick_id_c;
      grant_valid_d = 1'b1;
      ptr_d         = pick_id_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= IDW'(N - 1);
      hold_q        <= '0;
    end else begin
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Checks three arbiter configurations (RR unlocked, RR locked MAX_HOLD=3, fixed unlocked) against hand-derived grants.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;

  logic [3:0] g_rr, g_lk, g_fx;
  logic [1:0] id_rr, id_lk, id_fx;
  logic       v_rr, v_lk, v_fx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.N(4), .MODE(0), .LOCK(0), .MAX_HOLD(8)) u_rr (
    .clk(clk), .reset(reset), .request(request),
    .grant(g_rr), .grant_id(id_rr), .grant_valid(v_rr)
  );

  rr_arbiter #(.N(4), .MODE(0), .LOCK(1), .MAX_HOLD(3)) u_lk (
    .clk(clk), .reset(reset), .request(request),
    .grant(g_lk), .grant_id(id_lk), .grant_valid(v_lk)
  );

  rr_arbiter #(.N(4), .MODE(1), .LOCK(0), .MAX_HOLD(8)) u_fx (
    .clk(clk), .reset(reset), .request(request),
    .grant(g_fx), .grant_id(id_fx), .grant_valid(v_fx)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] e_rr;
    logic [3:0] e_lk;
    logic [3:0] e_fx;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] e_rr;
    logic [3:0] e_lk;
    logic [3:0] e_fx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic add(input logic rn, input logic [3:0] rq, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] c);
    vec_t v;
    v.rst_n = rn; v.req = rq; v.e_rr = a; v.e_lk = b; v.e_fx = c;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_one(input string tag, input int idx, input logic [3:0] g,
                           input logic [1:0] id, input logic v, input logic [3:0] eg);
    cmp({tag, ".grant"}, idx, g, eg);
    cmp({tag, ".grant_id"}, idx, {2'b00, id}, {2'b00, oh2id(eg)});
    cmp({tag, ".grant_valid"}, idx, {3'b000, v}, {3'b000, |eg});
  endtask

  task automatic check_all(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    check_one("rr", idx, g_rr, id_rr, v_rr, a);
    check_one("lk", idx, g_lk, id_lk, v_lk, b);
    check_one("fx", idx, g_fx, id_fx, v_fx, c);
  endtask

  task automatic push_exp(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    exp_t e;
    e.idx = idx; e.e_rr = a; e.e_lk = b; e.e_fx = c;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: no expected entry, got 0 expected 1");
    end else begin
      e = sb.pop_front();
      check_all(e.idx, e.e_rr, e.e_lk, e.e_fx);
    end
  endtask

  initial begin
    reset   = 1'b0;
    request = 4'b0000;

    //   rst  req      rr       lk       fx
    add(1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b1111, 4'b0001, 4'b0001, 4'b0001);
    add(1'b1, 4'b1111, 4'b0010, 4'b0001, 4'b0001);
    add(1'b1, 4'b1111, 4'b0100, 4'b0001, 4'b0001);
    add(1'b1, 4'b1111, 4'b1000, 4'b0010, 4'b0001);
    add(1'b1, 4'b1111, 4'b0001, 4'b0010, 4'b0001);
    add(1'b1, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    add(1'b1, 4'b0011, 4'b0010, 4'b0001, 4'b0001);
    add(1'b1, 4'b0011, 4'b0001, 4'b0001, 4'b0001);
    add(1'b1, 4'b0011, 4'b0010, 4'b0010, 4'b0001);
    add(1'b1, 4'b0011, 4'b0001, 4'b0010, 4'b0001);
    add(1'b1, 4'b0011, 4'b0010, 4'b0010, 4'b0001);
    add(1'b1, 4'b0011, 4'b0001, 4'b0001, 4'b0001);
    for (int k = 0; k < 5; k++) add(1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    add(1'b1, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
    add(1'b1, 4'b0110, 4'b0100, 4'b0010, 4'b0010);
    add(1'b1, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
    add(1'b1, 4'b1110, 4'b1000, 4'b0100, 4'b0010);
    add(1'b1, 4'b1110, 4'b0010, 4'b0100, 4'b0010);
    add(1'b1, 4'b1111, 4'b0100, 4'b1000, 4'b0001);
    add(1'b1, 4'b1111, 4'b1000, 4'b1000, 4'b0001);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      reset   = tbl[i].rst_n;
      request = tbl[i].req;
      push_exp(i, tbl[i].e_rr, tbl[i].e_lk, tbl[i].e_fx);
      @(negedge clk);
      pop_check();
    end

    // Every instance ends up granting 0100, then reset is pulsed between edges.
    request = 4'b0100;
    push_exp(100, 4'b0100, 4'b0100, 4'b0100);
    @(negedge clk);
    pop_check();
    #1 reset = 1'b0;
    #1 check_all(101, 4'b0000, 4'b0000, 4'b0000);
    #1 begin
      reset   = 1'b1;
      request = 4'b1111;
    end
    push_exp(102, 4'b0001, 4'b0001, 4'b0001);
    @(negedge clk);
    pop_check();

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
